// File: rtl/vvdot_reduce.sv
// vvdot_reduce: serial dot-product reduction, one vector element added per cycle.
// Saturating accumulation with a sticky overflow flag is enabled by defining VVDOT_SAT_EN.
module vvdot_reduce #(
  parameter int VECTOR_SIZE = 16,
  parameter int INT_SIZE    = 16,
  parameter int ACC_SIZE    = 20
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  in_vec,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ACC_SIZE-1:0]                   out_sum,
  output logic                                  out_ovf
);

  localparam int IDX_W = $clog2(VECTOR_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] vec_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [ACC_SIZE-1:0] sum_q, sum_d;
  vec_t                vec_q, vec_d;
  logic [ACC_SIZE-1:0] elem_ext;
  logic [ACC_SIZE-1:0] acc_add;
  logic                accept;

  assign elem_ext = ACC_SIZE'(vec_q[idx_q]);
  assign accept   = (state_q == IDLE) && in_valid;

`ifdef VVDOT_SAT_EN
  logic [ACC_SIZE:0] sum_wide;
  logic              add_ovf;
  logic              ovf_q, ovf_d;

  // Once a vector has overflowed, every later addition stays clamped at full scale.
  always_comb begin
    sum_wide = {1'b0, acc_q} + {1'b0, elem_ext};
    add_ovf  = sum_wide[ACC_SIZE] | ovf_q;
    acc_add  = add_ovf ? '1 : sum_wide[ACC_SIZE-1:0];
    ovf_d    = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (state_q == ACCUM) begin
      ovf_d = add_ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = (state_q == DONE) && ovf_q;
`else
  assign acc_add = acc_q + elem_ext;
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          vec_d   = in_vec;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_add;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_add;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      // NOTE: the captured vector is cleared on reset so nothing stale is ever summed.
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      vec_q   <= vec_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;

endmodule

// File: tb/tb_vvdot_reduce.sv
// Self-checking bench for vvdot_reduce: transaction-level reference model plus directed and random stimulus.
module tb_vvdot_reduce;

  localparam int VS   = 16;
  localparam int IW   = 16;
  localparam int AW   = 20;
  localparam int AW18 = 18;

`ifdef VVDOT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [VS-1:0][IW-1:0] vec_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            out_ready;
  vec_t            in_vec;
  logic            in_ready, out_valid, out_ovf;
  logic [AW-1:0]   out_sum;
  logic            in_ready18, out_valid18, out_ovf18;
  logic [AW18-1:0] out_sum18;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  vvdot_reduce #(.VECTOR_SIZE(VS), .INT_SIZE(IW), .ACC_SIZE(AW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  vvdot_reduce #(.VECTOR_SIZE(VS), .INT_SIZE(IW), .ACC_SIZE(AW18)) dut18 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready18), .in_vec(in_vec),
    .out_valid(out_valid18), .out_ready(out_ready),
    .out_sum(out_sum18), .out_ovf(out_ovf18)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint vec_total(input vec_t v);
    longint t = 0;
    for (int i = 0; i < VS; i++) t += longint'(v[i]);
    return t;
  endfunction

  function automatic longint ref_sum(input vec_t v, input int aw);
    longint mx = (longint'(1) << aw) - 1;
    longint t  = vec_total(v);
    return (SAT_EN && t > mx) ? mx : (t & mx);
  endfunction

  function automatic logic ref_ovf(input vec_t v, input int aw);
    return SAT_EN && (vec_total(v) > ((longint'(1) << aw) - 1));
  endfunction

  function automatic vec_t fill_vec(input logic [IW-1:0] val);
    vec_t v;
    for (int i = 0; i < VS; i++) v[i] = val;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VS; i++) v[i] = IW'($urandom);
    return v;
  endfunction

  // Transaction model: an accepted vector produces its result VS edges later and
  // holds it until the downstream handshake.
  logic          m_busy, m_done, m_ovf, r_ovf;
  logic [AW-1:0] m_sum, r_sum;
  int            m_cnt;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_ovf  <= 1'b0;
      m_cnt  <= 0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_sum  <= r_sum;
        m_ovf  <= r_ovf;
      end
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= VS;
      r_sum  <= AW'(ref_sum(in_vec, AW));
      r_ovf  <= ref_ovf(in_vec, AW);
    end
  end

  always @(negedge clock) begin
    if (cyc > 0) begin
      check("model_in_ready",  32'(in_ready),  32'(!(m_busy || m_done)));
      check("model_out_valid", 32'(out_valid), 32'(m_done));
      check("model_out_sum",   32'(out_sum),   32'(m_sum));
      check("model_out_ovf",   32'(out_ovf),   32'(m_done & m_ovf));
    end
  end

  // Present v and return the edge number on which it was accepted.
  task automatic send(input vec_t v, input bit hold_valid, output int acc_cyc);
    in_vec   = v;
    in_valid = 1'b1;
    acc_cyc  = -1;
    for (int i = 0; i < 100 && acc_cyc < 0; i++) begin
      if (in_ready) begin
        @(negedge clock);
        acc_cyc = cyc;
      end else begin
        @(negedge clock);
      end
    end
    if (acc_cyc < 0) check("accept_timeout", 32'(in_ready), 32'd1);
    if (!hold_valid) begin
      in_valid = 1'b0;
      in_vec   = rand_vec();
    end
  endtask

  task automatic wait_valid(output int rise_cyc);
    rise_cyc = -1;
    for (int i = 0; i < 100 && rise_cyc < 0; i++) begin
      if (out_valid) rise_cyc = cyc;
      else @(negedge clock);
    end
    if (rise_cyc < 0) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int   acc_n, rise_n, acc_b, done_cnt;
    vec_t v;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Basic sum and latency
    out_ready = 1'b1;
    v = '0;
    v[0] = IW'(4);
    v[1] = IW'(8);
    send(v, 1'b0, acc_n);
    wait_valid(rise_n);
    check("latency",       32'(rise_n - acc_n), 32'(VS));
    check("sum_4_8",       32'(out_sum),        32'd12);
    check("ovf_4_8",       32'(out_ovf),        32'd0);
    check("in_ready_done", 32'(in_ready),       32'd0);

    // Full-scale elements: fits in 20 bits, overflows 18 bits
    send(fill_vec(16'hFFFF), 1'b0, acc_n);
    wait_valid(rise_n);
    check("full_sum20",    32'(out_sum),     32'h000F_FFF0);
    check("full_ovf20",    32'(out_ovf),     32'd0);
    check("full_valid18",  32'(out_valid18), 32'd1);
    check("full_sum18",    32'(out_sum18),   SAT_EN ? 32'h0003_FFFF : 32'h0003_FFF0);
    check("full_ovf18",    32'(out_ovf18),   SAT_EN ? 32'd1 : 32'd0);

    // Backpressure in DONE with an ignored input pulse
    @(negedge clock);
    out_ready = 1'b0;
    send(fill_vec(16'd3), 1'b0, acc_n);
    wait_valid(rise_n);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_vec   = rand_vec();
      @(negedge clock);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum",   32'(out_sum),   32'd48);
      check("bp_out_ovf",   32'(out_ovf),   32'd0);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset five edges after accept
    send(rand_vec(), 1'b0, acc_n);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    v = '0;
    v[3] = IW'(7);
    send(v, 1'b0, acc_n);
    wait_valid(rise_n);
    check("after_rst_sum", 32'(out_sum), 32'd7);

    // Back-to-back vectors with in_valid held high
    @(negedge clock);
    send(fill_vec(16'd1), 1'b1, acc_n);
    in_vec = fill_vec(16'd2);
    wait_valid(rise_n);
    check("b2b_sum_a", 32'(out_sum), 32'd16);
    send(fill_vec(16'd2), 1'b0, acc_b);
    check("b2b_accept_gap", 32'(acc_b - rise_n), 32'd2);
    wait_valid(rise_n);
    check("b2b_sum_b", 32'(out_sum), 32'd32);

    // Random traffic against the model
    done_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) done_cnt++;
      in_valid  = ($urandom_range(1, 0) == 1);
      in_vec    = rand_vec();
      out_ready = ($urandom_range(3, 0) != 0);
    end
    check("random_results_seen", 32'(done_cnt > 10), 32'd1);

    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
